// File: rtl/trap_sequencer.sv
// Machine-mode trap entry/exit sequencer: serialises mepc/mcause/mtval/mstatus writes and redirects
// fetch. Optional macro TRAP_MTVAL_EN adds the W_MTVAL state and the captured tval register.

`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef MACHINE
`define MACHINE 2'b11
`endif
`ifndef NO_E
`define NO_E 4'hF
`endif
`ifndef E_FETCH_MISALIGNED
`define E_FETCH_MISALIGNED 4'd0
`endif
`ifndef E_ILLEGAL_INSTR
`define E_ILLEGAL_INSTR 4'd2
`endif
`ifndef E_LOAD_MISALIGNED
`define E_LOAD_MISALIGNED 4'd4
`endif
`ifndef E_LOAD_ACCESS_FAULT
`define E_LOAD_ACCESS_FAULT 4'd5
`endif
`ifndef E_STORE_MISALIGNED
`define E_STORE_MISALIGNED 4'd6
`endif
`ifndef E_STORE_ACCESS_FAULT
`define E_STORE_ACCESS_FAULT 4'd7
`endif
`ifndef E_ECALL
`define E_ECALL 4'd8
`endif

module trap_sequencer #(
    parameter int unsigned XLEN         = `XLEN_64b,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [3:0]                  i_exception_code_f,
    input  logic [3:0]                  i_exception_code_e,
    input  logic [(1 << (XLEN+4))-1:0]  i_pc_f,
    input  logic [(1 << (XLEN+4))-1:0]  i_pc_e,
    input  logic [(1 << (XLEN+4))-1:0]  i_alu_out_e,
    input  logic                        i_mret_e,
    input  logic [(1 << (XLEN+4))-1:0]  i_mtvec,
    input  logic [(1 << (XLEN+4))-1:0]  i_mepc,
    input  logic [(1 << (XLEN+4))-1:0]  i_mstatus,
    output logic                        o_csr_we,
    output logic [11:0]                 o_csr_waddr,
    output logic [(1 << (XLEN+4))-1:0]  o_csr_wdata,
    output logic                        o_flush,
    output logic                        o_stall_f,
    output logic                        o_pc_redirect_en,
    output logic [(1 << (XLEN+4))-1:0]  o_pc_redirect,
    output logic [1:0]                  o_current_privilege,
    output logic                        o_disable_exceptions_1cc,
    output logic                        o_busy
);
    localparam int unsigned W    = 1 << (XLEN + 4);
    localparam int unsigned CntW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StWMepc,
        StWMcause,
`ifdef TRAP_MTVAL_EN
        StWMtval,
`endif
        StWMstatus,
        StRedirect,
        StMretWr
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      priv_q, priv_d;
    logic [W-1:0]    epc_q, epc_d;
    logic [3:0]      cause_q, cause_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    redirect_q, redirect_d;
    logic            dis_q;
`ifdef TRAP_MTVAL_EN
    logic [W-1:0]    tval_q, tval_d;
    logic            unused_inputs;
    assign unused_inputs = ^i_mtvec[1:0];
`else
    logic            unused_inputs;
    assign unused_inputs = ^{i_mtvec[1:0], i_alu_out_e};
`endif

    // Exception codes share the mcause numbering; only ecall depends on privilege.
    function automatic logic [3:0] map_cause(input logic [3:0] code, input logic [1:0] priv);
        if (code == `E_ECALL) return 4'd8 + {2'b00, priv};
        return code;
    endfunction

    logic       sample_en, e_evt, mret_evt, f_evt;
    logic [3:0] e_code;
    logic [W-1:0] mstatus_trap, mstatus_mret;

    assign sample_en = (state_q == StIdle || state_q == StDrain) && !dis_q;
    assign e_evt     = (i_exception_code_e != `NO_E) || (i_mret_e && priv_q != `MACHINE);
    assign e_code    = (i_exception_code_e != `NO_E) ? i_exception_code_e : `E_ILLEGAL_INSTR;
    assign mret_evt  = i_mret_e && priv_q == `MACHINE;
    assign f_evt     = i_exception_code_f != `NO_E;

    always_comb begin
        mstatus_trap         = i_mstatus;
        mstatus_trap[7]      = i_mstatus[3];
        mstatus_trap[3]      = 1'b0;
        mstatus_trap[12:11]  = priv_q;
        mstatus_mret         = i_mstatus;
        mstatus_mret[3]      = i_mstatus[7];
        mstatus_mret[7]      = 1'b1;
        mstatus_mret[12:11]  = 2'b00;
    end

    always_comb begin
        state_d     = state_q;
        priv_d      = priv_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;
        redirect_d  = redirect_q;
`ifdef TRAP_MTVAL_EN
        tval_d      = tval_q;
`endif
        o_csr_we    = 1'b0;
        o_csr_waddr = 12'h000;
        o_csr_wdata = '0;
        unique case (state_q)
            StIdle, StDrain: begin
                if (state_q == StDrain) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CntW'(1)) state_d = StWMepc;
                end
                if (sample_en) begin
                    // An E exception is older than a pending F exception and replaces it.
                    if (e_evt) begin
                        epc_d   = i_pc_e;
                        cause_d = map_cause(e_code, priv_q);
`ifdef TRAP_MTVAL_EN
                        tval_d  = (e_code >= `E_LOAD_MISALIGNED &&
                                   e_code <= `E_STORE_ACCESS_FAULT) ? i_alu_out_e : '0;
`endif
                        state_d = StWMepc;
                    end else if (mret_evt) begin
                        state_d = StMretWr;
                    end else if (f_evt && state_q == StIdle) begin
                        epc_d   = i_pc_f;
                        cause_d = map_cause(i_exception_code_f, priv_q);
`ifdef TRAP_MTVAL_EN
                        tval_d  = (i_exception_code_f == `E_FETCH_MISALIGNED) ? i_pc_f : '0;
`endif
                        cnt_d   = CntW'(DRAIN_CYCLES);
                        state_d = (DRAIN_CYCLES == 0) ? StWMepc : StDrain;
                    end
                end
            end
            StWMepc: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = 12'h341;
                o_csr_wdata = epc_q;
                state_d     = StWMcause;
            end
            StWMcause: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = 12'h342;
                o_csr_wdata = {{(W-4){1'b0}}, cause_q};
`ifdef TRAP_MTVAL_EN
                state_d     = StWMtval;
            end
            StWMtval: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = 12'h343;
                o_csr_wdata = tval_q;
`endif
                state_d     = StWMstatus;
            end
            StWMstatus: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = 12'h300;
                o_csr_wdata = mstatus_trap;
                priv_d      = `MACHINE;
                redirect_d  = {i_mtvec[W-1:2], 2'b00};
                state_d     = StRedirect;
            end
            StMretWr: begin
                o_csr_we    = 1'b1;
                o_csr_waddr = 12'h300;
                o_csr_wdata = mstatus_mret;
                priv_d      = i_mstatus[12:11];
                redirect_d  = i_mepc;
                state_d     = StRedirect;
            end
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            priv_q     <= `MACHINE;
            epc_q      <= '0;
            cause_q    <= '0;
            cnt_q      <= '0;
            redirect_q <= '0;
            dis_q      <= 1'b0;
`ifdef TRAP_MTVAL_EN
            tval_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            priv_q     <= priv_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            dis_q      <= (state_q == StRedirect);
`ifdef TRAP_MTVAL_EN
            tval_q     <= tval_d;
`endif
        end
    end

    assign o_busy                   = (state_q != StIdle);
    assign o_stall_f                = (state_q != StIdle);
    assign o_flush                  = (state_q != StIdle) && (state_q != StDrain);
    assign o_pc_redirect_en         = (state_q == StRedirect);
    assign o_pc_redirect            = (state_q == StRedirect) ? redirect_q : '0;
    assign o_current_privilege      = priv_q;
    assign o_disable_exceptions_1cc = dis_q;

endmodule
